branch_pc_unit: RTL and testbench

Program-counter register and branch/jump resolution for the RISC-V single-cycle core. It consumes the ALU's `Z_flag`/`N_flag`/`C_flag`/`V_flag` and `Result` after a compare (SUB) or address add, evaluates the B-type condition, and selects the next PC. Misaligned control-flow targets raise a trap and halt the PC until the trap is acknowledged. It also keeps a free-running count of taken redirects.

---
 rtl/branch_pc_unit.sv | 122 ++++++++++++
 tb/tb_branch_pc_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Program counter plus branch/jump resolution for the single-cycle core.
//   Evaluates the B-type condition from the ALU flags of A-B, picks the next
//   PC, traps on misaligned control-flow targets, and counts committed
//   redirects.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   Z_flag/N_flag/C_flag/V_flag ALU flags of A-B (C=1 means A >= B unsigned)
//   Result                      ALU result, JALR target (rs1+imm)
//   imm                         sign-extended B/J immediate
//   funct3                      branch condition select
//   branch, jump, jalr          decoder control (jalr > jump > branch)
//   stall                       holds PC while running
//   trap_ack                    leaves the halted trap state
//   pc                          current PC (registered)
//   pc_plus4                    pc+4, combinational link value
//   branch_taken                combinational redirect decision
//   misalign_trap               registered, high while halted
//   bad_target                  misaligned target captured at trap entry
//   redirect_cnt                count of committed redirects (wraps)
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Z_flag,
  input  logic        N_flag,
  input  logic        C_flag,
  input  logic        V_flag,
  input  logic [31:0] Result,
  input  logic [31:0] imm,
  input  logic [2:0]  funct3,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic        stall,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        branch_taken,
  output logic        misalign_trap,
  output logic [31:0] bad_target,
  output logic [31:0] redirect_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        trap_q;
  logic [31:0] bad_q;
  logic [31:0] redirect_cnt_q;

  logic        cond;
  logic [31:0] target;
  logic        misaligned;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = Z_flag;
      3'b001:  cond = !Z_flag;
      3'b100:  cond = N_flag ^ V_flag;
      3'b101:  cond = !(N_flag ^ V_flag);
      3'b110:  cond = !C_flag;
      3'b111:  cond = C_flag;
      default: cond = 1'b0;
    endcase
  end

  // Jump and taken branch share the pc-relative adder; JALR clears bit 0
  // first, so a target with bit 1 set still fails the alignment check.
  assign target       = jalr ? {Result[31:1], 1'b0} : (pc_q + imm);
  assign misaligned   = |target[1:0];
  assign branch_taken = jalr | jump | (branch & cond);
  assign pc_plus4     = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      trap_q         <= 1'b0;
      bad_q          <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (branch_taken && misaligned) begin
              // PC and counter stay put; the faulting target is recorded.
              state_q <= HALT;
              trap_q  <= 1'b1;
              bad_q   <= target;
            end else if (branch_taken) begin
              pc_q           <= target;
              redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        HALT: begin
          // stall is irrelevant here; only the acknowledge moves us on.
          if (trap_ack) begin
            state_q <= RUN;
            pc_q    <= TRAP_VECTOR;
            trap_q  <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc            = pc_q;
  assign misalign_trap = trap_q;
  assign bad_target    = bad_q;
  assign redirect_cnt  = redirect_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit. The driver presents one cycle of
// stimulus, evaluates a reference model built from compare semantics on the
// operands A and B, and queues expected combinational and registered results;
// independent monitors pop and compare.
module tb_branch_pc_unit;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Z_flag = 1'b0, N_flag = 1'b0, C_flag = 1'b0, V_flag = 1'b0;
  logic [31:0] Result = 32'h0, imm = 32'h0;
  logic [2:0]  funct3 = 3'b0;
  logic        branch = 1'b0, jump = 1'b0, jalr = 1'b0, stall = 1'b0, trap_ack = 1'b0;
  logic [31:0] pc, pc_plus4, bad_target, redirect_cnt;
  logic        branch_taken, misalign_trap;

  branch_pc_unit #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .Z_flag(Z_flag), .N_flag(N_flag), .C_flag(C_flag), .V_flag(V_flag),
    .Result(Result), .imm(imm), .funct3(funct3),
    .branch(branch), .jump(jump), .jalr(jalr), .stall(stall), .trap_ack(trap_ack),
    .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .misalign_trap(misalign_trap), .bad_target(bad_target), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        trap;
    logic [31:0] bad;
    logic [31:0] cnt;
  } st_t;

  st_t         seqq[$];
  logic [32:0] combq[$];   // {branch_taken, pc_plus4}

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_bad, m_cnt;
  logic        m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_bad = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
  endtask

  // One cycle of stimulus: operands a,b produce the ALU flags of a-b.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] im,
                       input logic [2:0] f3, input logic br, input logic jp,
                       input logic jr, input logic st, input logic ack);
    logic [31:0] d, tgt;
    logic        c, taken;
    @(negedge clk); #1;
    d = a - b;
    Z_flag = (d == 32'h0);
    N_flag = d[31];
    C_flag = (a >= b);
    V_flag = (a[31] != b[31]) && (d[31] != a[31]);
    Result = res; imm = im; funct3 = f3;
    branch = br; jump = jp; jalr = jr; stall = st; trap_ack = ack;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) <  $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a <  b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    taken = jr || jp || (br && c);
    tgt   = jr ? (res & 32'hFFFF_FFFE) : (m_pc + im);
    combq.push_back({taken, m_pc + 32'd4});
    if (m_halt) begin
      if (ack) begin m_pc = TRAP_VECTOR; m_halt = 1'b0; end
    end else if (!st) begin
      if (taken && (tgt % 4 != 0)) begin m_halt = 1'b1; m_bad = tgt; end
      else if (taken) begin m_pc = tgt; m_cnt = m_cnt + 32'd1; end
      else m_pc = m_pc + 32'd4;
    end
    seqq.push_back('{pc: m_pc, trap: m_halt, bad: m_bad, cnt: m_cnt});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic go_to(input logic [31:0] addr);
    drive(0, 0, 0, addr - m_pc, 3'd0, 0, 1, 0, 0, 0);
  endtask

  // Registered-output monitor
  always @(posedge clk) begin
    st_t e;
    #1;
    if (rst_n && seqq.size() > 0) begin
      e = seqq.pop_front();
      chk("pc", pc, e.pc);
      chk("misalign_trap", {31'h0, misalign_trap}, {31'h0, e.trap});
      chk("bad_target", bad_target, e.bad);
      chk("redirect_cnt", redirect_cnt, e.cnt);
    end
  end

  // Combinational-output monitor, sampled after the driver settles inputs
  always @(negedge clk) begin
    logic [32:0] e;
    #3;
    if (combq.size() > 0) begin
      e = combq.pop_front();
      chk("branch_taken", {31'h0, branch_taken}, {31'h0, e[32]});
      chk("pc_plus4", pc_plus4, e[31:0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [2:0]  f3s [8];
    pa = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'd1};
    pb = '{32'd5, 32'd10, 32'd1, 32'hFFFF_FFFF};
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, RESET_PC);
    chk("reset_cnt", redirect_cnt, 32'h0);
    chk("reset_trap", {31'h0, misalign_trap}, 32'h0);
    chk("reset_bad", bad_target, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Sequential fetch: 0x4, 0x8, 0xC, 0x10
    repeat (4) idle();

    // Every condition against every operand pair from pc=0x10
    foreach (f3s[k])
      for (int p = 0; p < 4; p++) begin
        go_to(32'h10);
        drive(pa[p], pb[p], 0, 32'h20, f3s[k], 1, 0, 0, 0, 0);
      end

    // JALR: bit 0 cleared, then bit-1 target traps; ack on entry ignored
    drive(0, 0, 32'h1235, 0, 3'd0, 0, 0, 1, 0, 0);
    drive(0, 0, 32'h1236, 0, 3'd0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 32'h40, 3'd0, 0, 1, 0, 1, 0);   // halted: stall/jump ignored
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);        // ack -> trap vector

    // Stall holds a taken jump, then it goes through
    drive(0, 0, 0, 32'h80, 3'd0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h80, 3'd0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h80, 3'd0, 0, 1, 0, 0, 0);

    // Priority: jalr wins over jump and taken branch
    drive(7, 7, 32'h2000, 32'h40, 3'd0, 1, 1, 1, 0, 0);
    drive(7, 7, 32'h3000, 32'h40, 3'd0, 1, 1, 0, 0, 0);

    // PC wrap
    go_to(32'hFFFF_FFFC);
    idle();

    // Counter wrap: preload just below the top
    @(posedge clk); #2;
    force dut.redirect_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.redirect_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(0, 0, 0, 32'h8, 3'd0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h8, 3'd0, 0, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, im;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      drive(a, b, $urandom, im, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0));
    end

    // Async reset while halted
    if (m_halt) drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);
    drive(0, 0, 32'h1236, 0, 3'd0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_trap", {31'h0, misalign_trap}, 32'h0);
    chk("async_rst_pc", pc, RESET_PC);
    chk("async_rst_cnt", redirect_cnt, 32'h0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    idle();
    idle();

    @(posedge clk); #3;
    chk("scoreboard_drained", seqq.size() + combq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
